onehot_mask_gen: RTL and testbench

ONEHOT_MASK_GEN -- requirements
Module: onehot_mask_gen

---
 rtl/onehot_mask_gen_pkg.sv | 29 ++
 rtl/onehot_mask_decode.sv | 30 +++
 rtl/onehot_mask_gen.sv | 134 +++++++++++++
 tb/tb_onehot_mask_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_mask_gen_pkg.sv
// rtl/onehot_mask_gen_pkg.sv - shared mode encodings, defaults, FSM states and clog2 helper
package onehot_mask_gen_pkg;

    localparam int DATA_WIDTH_DEF = 64;

    localparam logic [1:0] MODE_ONEHOT = 2'd0;
    localparam logic [1:0] MODE_THERMO = 2'd1;
    localparam logic [1:0] MODE_ACCUM  = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    // Ceiling log2, minimum 1 so a 2-bit mask still gets a 1-bit index.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_mask_decode.sv
// rtl/onehot_mask_decode.sv - combinational index-to-mask decode with range check
module onehot_mask_decode
    import onehot_mask_gen_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IDX_W      = clog2(DATA_WIDTH)
) (
    input  logic [IDX_W-1:0]      index,
    input  logic                  thermo,
    output logic [DATA_WIDTH-1:0] mask,
    output logic                  oor
);

    logic [31:0] idx_u;

    assign idx_u = 32'(index);

    // Out-of-range indices force an all-zero mask, including the thermometer case.
    always_comb begin
        oor = (idx_u >= 32'(DATA_WIDTH));
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (thermo) begin
                mask[i] = !oor && (32'(i) <= idx_u);
            end else begin
                mask[i] = !oor && (32'(i) == idx_u);
            end
        end
    end

endmodule

// File: rtl/onehot_mask_gen.sv
// rtl/onehot_mask_gen.sv - one-hot / thermometer / accumulated mask generator with registered output
module onehot_mask_gen
    import onehot_mask_gen_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IDX_W      = clog2(DATA_WIDTH),
    parameter int CNT_W      = IDX_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [IDX_W-1:0]      s_index,
    input  logic [1:0]            s_mode,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_mask,
    output logic [CNT_W-1:0]      m_count,
    output logic                  m_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]        acc_cnt_q, acc_cnt_d;
    logic                    acc_err_q, acc_err_d;
    logic                    m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]   m_mask_q, m_mask_d;
    logic [CNT_W-1:0]        m_count_q, m_count_d;
    logic                    m_err_q, m_err_d;

    logic                    accept;
    logic                    beat_accum;
    logic                    dec_thermo;
    logic [DATA_WIDTH-1:0]   dec_mask;
    logic                    dec_oor;
    logic [DATA_WIDTH-1:0]   sum_mask;
    logic [CNT_W-1:0]        sum_cnt;
    logic                    sum_err;

    assign s_ready    = !m_valid_q || m_ready;
    assign accept     = s_valid && s_ready;
    // Mode only matters in IDLE; inside a burst every beat is an ACCUM beat.
    assign beat_accum = (state_q == ST_ACC) || (s_mode == MODE_ACCUM);
    assign dec_thermo = (state_q == ST_IDLE) && (s_mode == MODE_THERMO);

    assign m_valid = m_valid_q;
    assign m_mask  = m_mask_q;
    assign m_count = m_count_q;
    assign m_err   = m_err_q;

    onehot_mask_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_decode (
        .index  (s_index),
        .thermo (dec_thermo),
        .mask   (dec_mask),
        .oor    (dec_oor)
    );

    // Next-state: fold beats into the accumulator, or load a fresh output word.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_cnt_d = acc_cnt_q;
        acc_err_d = acc_err_q;
        m_valid_d = m_valid_q && !m_ready;
        m_mask_d  = m_mask_q;
        m_count_d = m_count_q;
        m_err_d   = m_err_q;

        sum_mask = acc_q | dec_mask;
        sum_cnt  = (acc_cnt_q == CNT_MAX) ? acc_cnt_q : acc_cnt_q + CNT_ONE;
        sum_err  = acc_err_q | dec_oor;

        if (accept) begin
            if (beat_accum) begin
                if (s_last) begin
                    m_valid_d = 1'b1;
                    m_mask_d  = sum_mask;
                    m_count_d = sum_cnt;
                    m_err_d   = sum_err;
                    acc_d     = '0;
                    acc_cnt_d = '0;
                    acc_err_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    acc_d     = sum_mask;
                    acc_cnt_d = sum_cnt;
                    acc_err_d = sum_err;
                    state_d   = ST_ACC;
                end
            end else if (s_mode == MODE_RSVD) begin
                m_valid_d = 1'b1;
                m_mask_d  = '0;
                m_count_d = CNT_ONE;
                m_err_d   = 1'b1;
            end else begin
                m_valid_d = 1'b1;
                m_mask_d  = dec_mask;
                m_count_d = CNT_ONE;
                m_err_d   = dec_oor;
            end
        end
    end

    // State and output registers; reset drops any partial burst and pending output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            acc_cnt_q <= '0;
            acc_err_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_mask_q  <= '0;
            m_count_q <= '0;
            m_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_cnt_q <= acc_cnt_d;
            acc_err_q <= acc_err_d;
            m_valid_q <= m_valid_d;
            m_mask_q  <= m_mask_d;
            m_count_q <= m_count_d;
            m_err_q   <= m_err_d;
        end
    end

endmodule

// File: tb/tb_onehot_mask_gen.sv
// tb/tb_onehot_mask_gen.sv - randomized and directed self-checking bench for onehot_mask_gen
module tb_onehot_mask_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [5:0]  s_index;
    logic [1:0]  s_mode;
    logic        s_last;
    logic        m_ready;

    logic        s_ready_a, m_valid_a, m_err_a;
    logic [63:0] m_mask_a;
    logic [6:0]  m_count_a;
    logic        s_ready_b, m_valid_b, m_err_b;
    logic [39:0] m_mask_b;
    logic [6:0]  m_count_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending output word plus the list of indices in the open burst.
    bit          exp_valid;
    logic [63:0] exp_mask_a, exp_mask_b;
    int          exp_cnt;
    bit          exp_err_a, exp_err_b;
    bit          in_acc;
    int          burst[$];

    always #5 clk = ~clk;

    onehot_mask_gen #(.DATA_WIDTH(64)) u_dut_a (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_a),
        .s_index(s_index), .s_mode(s_mode), .s_last(s_last),
        .m_valid(m_valid_a), .m_ready(m_ready), .m_mask(m_mask_a),
        .m_count(m_count_a), .m_err(m_err_a)
    );

    onehot_mask_gen #(.DATA_WIDTH(40)) u_dut_b (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b),
        .s_index(s_index), .s_mode(s_mode), .s_last(s_last),
        .m_valid(m_valid_b), .m_ready(m_ready), .m_mask(m_mask_b),
        .m_count(m_count_b), .m_err(m_err_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Mask a single index contributes for a mask of width w.
    function automatic logic [63:0] beat_mask(input int w, input int idx, input bit thermo);
        logic [63:0] one;
        one = 64'd1;
        if (idx >= w) return 64'd0;
        if (thermo) return (one << (idx + 1)) - one;
        return one << idx;
    endfunction

    task automatic emit_burst();
        exp_mask_a = 64'd0;
        exp_mask_b = 64'd0;
        exp_err_a  = 1'b0;
        exp_err_b  = 1'b0;
        foreach (burst[k]) begin
            exp_mask_a |= beat_mask(64, burst[k], 1'b0);
            exp_mask_b |= beat_mask(40, burst[k], 1'b0);
            if (burst[k] >= 64) exp_err_a = 1'b1;
            if (burst[k] >= 40) exp_err_b = 1'b1;
        end
        exp_cnt = (burst.size() > 127) ? 127 : burst.size();
        burst.delete();
    endtask

    // One clock: drive inputs, check s_ready, advance the model, check registered outputs.
    task automatic step(input bit v, input int idx, input int mode, input bit last,
                        input bit rdy, input bit r);
        bit acc;
        bit produced;
        s_valid = v;
        s_index = 6'(idx);
        s_mode  = 2'(mode);
        s_last  = last;
        m_ready = rdy;
        rst     = r;
        #1;
        check_eq("s_ready_a", 64'(s_ready_a), 64'(!exp_valid || rdy));
        check_eq("s_ready_b", 64'(s_ready_b), 64'(!exp_valid || rdy));
        if (r) begin
            exp_valid  = 1'b0;
            exp_mask_a = 64'd0;
            exp_mask_b = 64'd0;
            exp_cnt    = 0;
            exp_err_a  = 1'b0;
            exp_err_b  = 1'b0;
            in_acc     = 1'b0;
            burst.delete();
        end else begin
            acc      = v && (!exp_valid || rdy);
            produced = 1'b0;
            if (acc) begin
                if (in_acc || mode == 2) begin
                    burst.push_back(idx);
                    if (last) begin
                        emit_burst();
                        in_acc   = 1'b0;
                        produced = 1'b1;
                    end else begin
                        in_acc = 1'b1;
                    end
                end else if (mode == 3) begin
                    exp_mask_a = 64'd0;
                    exp_mask_b = 64'd0;
                    exp_err_a  = 1'b1;
                    exp_err_b  = 1'b1;
                    exp_cnt    = 1;
                    produced   = 1'b1;
                end else begin
                    exp_mask_a = beat_mask(64, idx, mode == 1);
                    exp_mask_b = beat_mask(40, idx, mode == 1);
                    exp_err_a  = (idx >= 64);
                    exp_err_b  = (idx >= 40);
                    exp_cnt    = 1;
                    produced   = 1'b1;
                end
            end
            exp_valid = produced || (exp_valid && !rdy);
        end
        @(posedge clk);
        #1;
        check_eq("m_valid_a", 64'(m_valid_a), 64'(exp_valid));
        check_eq("m_mask_a",  m_mask_a,       exp_mask_a);
        check_eq("m_count_a", 64'(m_count_a), 64'(exp_cnt));
        check_eq("m_err_a",   64'(m_err_a),   64'(exp_err_a));
        check_eq("m_valid_b", 64'(m_valid_b), 64'(exp_valid));
        check_eq("m_mask_b",  64'(m_mask_b),  exp_mask_b);
        check_eq("m_count_b", 64'(m_count_b), 64'(exp_cnt));
        check_eq("m_err_b",   64'(m_err_b),   64'(exp_err_b));
    endtask

    initial begin
        exp_valid  = 1'b0;
        exp_mask_a = 64'd0;
        exp_mask_b = 64'd0;
        exp_cnt    = 0;
        exp_err_a  = 1'b0;
        exp_err_b  = 1'b0;
        in_acc     = 1'b0;

        // Reset, then an idle cycle shows reset values and s_ready high.
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0);
        check_eq("rst_m_valid", 64'(m_valid_a), 64'd0);
        check_eq("rst_s_ready", 64'(s_ready_a), 64'd1);

        // ONEHOT index 5.
        step(1, 5, 0, 0, 1, 0);
        check_eq("onehot5_mask", m_mask_a, 64'h20);
        check_eq("onehot5_cnt",  64'(m_count_a), 64'd1);
        check_eq("onehot5_err",  64'(m_err_a), 64'd0);

        // THERMO index 3 and index 63.
        step(1, 3, 1, 0, 1, 0);
        check_eq("thermo3_mask", m_mask_a, 64'h0F);
        step(1, 63, 1, 0, 1, 0);
        check_eq("thermo63_mask", m_mask_a, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("thermo63_b_err", 64'(m_err_b), 64'd1);
        check_eq("thermo63_b_mask", 64'(m_mask_b), 64'd0);

        // ACCUM burst 1,4,4,9.
        step(1, 1, 2, 0, 1, 0);
        step(1, 4, 2, 0, 1, 0);
        step(1, 4, 2, 0, 1, 0);
        check_eq("accum_no_early", 64'(m_valid_a), 64'd0);
        step(1, 9, 2, 1, 1, 0);
        check_eq("accum_mask", m_mask_a, 64'h212);
        check_eq("accum_cnt",  64'(m_count_a), 64'd4);

        // Width 40, ONEHOT index 45 is out of range.
        step(1, 45, 0, 0, 1, 0);
        check_eq("w40_idx45_mask", 64'(m_mask_b), 64'd0);
        check_eq("w40_idx45_err",  64'(m_err_b), 64'd1);

        // Reserved mode in IDLE.
        step(1, 2, 3, 0, 1, 0);
        check_eq("rsvd_err", 64'(m_err_a), 64'd1);

        // Back-pressure: first output held for 3 cycles while the second beat waits.
        step(1, 2, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 3, 0, 0, 0, 0);
            check_eq("stall_hold_mask", m_mask_a, 64'h4);
        end
        step(1, 3, 0, 0, 1, 0);
        check_eq("stall_release_mask", m_mask_a, 64'h8);
        step(0, 0, 0, 0, 1, 0);

        // Reset mid-burst discards it; a fresh single-beat burst follows.
        step(1, 2, 2, 0, 1, 0);
        step(1, 3, 2, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        check_eq("rst_burst_no_out", 64'(m_valid_a), 64'd0);
        step(1, 7, 2, 1, 1, 0);
        check_eq("post_rst_mask", m_mask_a, 64'h80);
        check_eq("post_rst_cnt",  64'(m_count_a), 64'd1);

        // Count saturation with a 130-beat burst, mode varied inside the burst.
        for (int k = 0; k < 130; k++) begin
            step(1, k % 64, (k == 0) ? 2 : (k % 4), (k == 129), 1, 0);
        end
        check_eq("sat_cnt",  64'(m_count_a), 64'd127);
        check_eq("sat_mask", m_mask_a, 64'hFFFF_FFFF_FFFF_FFFF);

        // Randomized traffic with back-pressure and occasional reset.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(3) != 0), $urandom_range(63), $urandom_range(3),
                 ($urandom_range(3) == 0), ($urandom_range(3) != 0),
                 ($urandom_range(99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
